// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load queue: load op codes,
// per-entry response state and the entry record.
// Optional feature macro: MEM_LWLR_EN (adds the per-entry rt field).
package mem_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam logic [2:0] LD_WL = 3'd5;
    localparam logic [2:0] LD_WR = 3'd6;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_DONE = 1'b1
    } ent_state_e;

    // The sideband is kept in a separate array in the queue because its
    // width is a module parameter.
    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  off;
`ifdef MEM_LWLR_EN
        logic [31:0] rt;
`endif
        logic [31:0] data;
        ent_state_e  st;
    } ent_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment and extension.
// Optional feature macro: MEM_LWLR_EN (LWL/LWR merge with the old rt value;
// without it ops 5/6 behave like LW and rt is ignored).
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rt,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        byte_sel = data[7:0];
        case (off)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        half_sel = off[1] ? data[31:16] : data[15:0];
    end

    // Extend or merge according to the load op; unknown ops act as LW.
    always_comb begin
        result = data;
        case (op)
            LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: result = {24'h0, byte_sel};
            LD_H:  result = {{16{half_sel[15]}}, half_sel};
            LD_HU: result = {16'h0, half_sel};
`ifdef MEM_LWLR_EN
            LD_WL: begin
                case (off)
                    2'd0: result = {data[7:0],  rt[23:0]};
                    2'd1: result = {data[15:0], rt[15:0]};
                    2'd2: result = {data[23:0], rt[7:0]};
                    default: result = data;
                endcase
            end
            LD_WR: begin
                case (off)
                    2'd1: result = {rt[31:24], data[31:8]};
                    2'd2: result = {rt[31:16], data[31:16]};
                    2'd3: result = {rt[31:8],  data[31:24]};
                    default: result = data;
                endcase
            end
`endif
            default: result = data;
        endcase
    end

`ifndef MEM_LWLR_EN
    logic unused_rt;
    assign unused_rt = ^rt;
`endif

endmodule

// File: rtl/ms_load_queue.sv
// Memory-stage load queue: tracks up to DEPTH outstanding data-SRAM loads
// in order, captures responses, aligns them and hands results to writeback.
// A flush cancels all entries; responses still owed to cancelled requests
// are counted in drop_cnt and swallowed when they arrive.
// Optional feature macro: MEM_LWLR_EN (LWL/LWR support, stores rt per entry).
module ms_load_queue
    import mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int META_W = 38
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [1:0]               req_off,
    input  logic [31:0]              req_rt,
    input  logic [META_W-1:0]        req_meta,
    input  logic                     data_ok,
    input  logic [31:0]              rdata,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [META_W-1:0]        out_meta,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    ent_t              ent_q  [DEPTH];
    logic [META_W-1:0] meta_q [DEPTH];

    logic [PW-1:0] push_ptr;
    logic [PW-1:0] resp_ptr;
    logic [PW-1:0] pop_ptr;
    logic [CW-1:0] occ_q;
    logic [CW-1:0] wait_q;
    logic [CW-1:0] drop_q;

    logic          do_push;
    logic          do_pop;
    logic          drop_hit;
    logic          resp_live;
    logic [CW:0]   used_sum;
    logic [CW-1:0] drop_nxt;
    logic [31:0]   head_rt;
    ent_t          head;

    assign head = ent_q[pop_ptr];

    // Handshakes and response routing; ready depends only on registered
    // counts so a same-cycle pop never frees a slot early.
    always_comb begin
        used_sum  = {1'b0, occ_q} + {1'b0, drop_q};
        req_ready = resetn && !flush && (used_sum < DEPTH_V);
        do_push   = req_valid && req_ready;
        drop_hit  = data_ok && (drop_q != '0);
        resp_live = data_ok && (drop_q == '0) && (wait_q != '0);
        out_valid = !flush && (occ_q != '0) && (head.st == ST_DONE);
        do_pop    = out_valid && out_ready;
    end

    // A flush turns every still-waiting entry into a response to swallow,
    // net of the one a same-cycle data_ok already consumed.
    always_comb begin
        drop_nxt = drop_q;
        if (drop_hit) begin
            drop_nxt = drop_q - CW'(1);
        end
        if (flush) begin
            drop_nxt = drop_nxt + wait_q - CW'(resp_live);
        end
    end

    // Pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            push_ptr <= '0;
            resp_ptr <= '0;
            pop_ptr  <= '0;
            occ_q    <= '0;
            wait_q   <= '0;
            drop_q   <= '0;
        end else begin
            drop_q <= drop_nxt;
            if (flush) begin
                push_ptr <= '0;
                resp_ptr <= '0;
                pop_ptr  <= '0;
                occ_q    <= '0;
                wait_q   <= '0;
            end else begin
                if (do_push) begin
                    push_ptr <= push_ptr + PW'(1);
                end
                if (resp_live) begin
                    resp_ptr <= resp_ptr + PW'(1);
                end
                if (do_pop) begin
                    pop_ptr <= pop_ptr + PW'(1);
                end
                occ_q  <= occ_q + CW'(do_push) - CW'(do_pop);
                wait_q <= wait_q + CW'(do_push) - CW'(resp_live);
            end
        end
    end

    // Entry storage: requests land in WAIT, responses flip them to DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]  <= '0;
                meta_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                ent_q[push_ptr].op  <= req_op;
                ent_q[push_ptr].off <= req_off;
`ifdef MEM_LWLR_EN
                ent_q[push_ptr].rt  <= req_rt;
`endif
                ent_q[push_ptr].st  <= ST_WAIT;
                meta_q[push_ptr]    <= req_meta;
            end
            if (resp_live) begin
                ent_q[resp_ptr].data <= rdata;
                ent_q[resp_ptr].st   <= ST_DONE;
            end
        end
    end

`ifdef MEM_LWLR_EN
    assign head_rt = head.rt;
`else
    assign head_rt = 32'h0;
    logic unused_req_rt;
    assign unused_req_rt = ^req_rt;
`endif

    load_align u_align (
        .op     (head.op),
        .off    (head.off),
        .rt     (head_rt),
        .data   (head.data),
        .result (out_data)
    );

    assign out_meta    = meta_q[pop_ptr];
    assign pending_cnt = occ_q + drop_q;

endmodule

// File: tb/tb_ms_load_queue.sv
// Self-checking bench for ms_load_queue with a request/expected-result
// scoreboard. Honors MEM_LWLR_EN for the expected LWL/LWR results.
module tb_ms_load_queue;

    localparam int DEPTH  = 2;
    localparam int META_W = 38;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [1:0]        req_off;
    logic [31:0]       req_rt;
    logic [META_W-1:0] req_meta;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [META_W-1:0] out_meta;
    logic [$clog2(DEPTH):0] pending_cnt;

    ms_load_queue #(.DEPTH(DEPTH), .META_W(META_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_off     (req_off),
        .req_rt      (req_rt),
        .req_meta    (req_meta),
        .data_ok     (data_ok),
        .rdata       (rdata),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_meta    (out_meta),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        op;
        logic [1:0]        off;
        logic [31:0]       rt;
        logic [META_W-1:0] meta;
    } treq_t;

    typedef struct {
        logic [31:0]       data;
        logic [META_W-1:0] meta;
    } texp_t;

    treq_t req_q[$];
    texp_t exp_q[$];
    texp_t stage_q[$];
    int    m_drop;
    int    checks;
    int    errors;
    logic  mon_ev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rt, input logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = d >> (8 * off);
        b  = sh[7:0];
        h  = off[1] ? d[31:16] : d[15:0];
        case (op)
            3'd1: return {{24{b[7]}}, b};
            3'd2: return {24'h0, b};
            3'd3: return {{16{h[15]}}, h};
            3'd4: return {16'h0, h};
`ifdef MEM_LWLR_EN
            3'd5: return (off == 2'd3) ? d : ((d << (8 * (3 - off))) | (rt & (32'hFFFF_FFFF >> (8 * (off + 1)))));
            3'd6: return (off == 2'd0) ? d : ((d >> (8 * off)) | (rt & ~(32'hFFFF_FFFF >> (8 * off))));
`endif
            default: return d;
        endcase
    endfunction

    // Output monitor: compares the head result whenever the model expects one.
    always @(negedge clk) begin
        if (resetn) begin
            mon_ev = (exp_q.size() > 0) && !flush;
            chk("out_valid", out_valid, mon_ev);
            if (mon_ev && out_ready) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_meta", out_meta, exp_q[0].meta);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus: check ready/occupancy, update the model, clock.
    task automatic step();
        logic  exp_rdy;
        treq_t r;
        texp_t e;
        logic  clr;
        clr = 1'b0;
        #1;
        exp_rdy = !flush && (req_q.size() + exp_q.size() + m_drop < DEPTH);
        chk("req_ready", req_ready, exp_rdy);
        chk("pending_cnt", pending_cnt, req_q.size() + exp_q.size() + m_drop);
        if (data_ok) begin
            if (m_drop > 0) begin
                m_drop--;
            end else if (req_q.size() > 0) begin
                r = req_q.pop_front();
                e.data = ref_load(r.op, r.off, r.rt, rdata);
                e.meta = r.meta;
                stage_q.push_back(e);
            end
        end
        if (req_valid && exp_rdy) begin
            r.op = req_op; r.off = req_off; r.rt = req_rt; r.meta = req_meta;
            req_q.push_back(r);
        end
        if (flush) begin
            m_drop += req_q.size();
            req_q.delete();
            stage_q.delete();
            clr = 1'b1;
        end
        @(posedge clk);
        if (clr) exp_q.delete();
        while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
        #1;
        req_valid = 1'b0;
        data_ok   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [1:0] off, input logic [31:0] rt);
        req_valid = 1'b1;
        req_op    = op;
        req_off   = off;
        req_rt    = rt;
        req_meta  = META_W'({$urandom(), $urandom()});
        step();
    endtask

    task automatic do_ok(input logic [31:0] d);
        data_ok = 1'b1;
        rdata   = d;
        step();
    endtask

    initial begin
        checks = 0; errors = 0; m_drop = 0;
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_off = '0; req_rt = '0;
        req_meta = '0; data_ok = 1'b0; rdata = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_meta", out_meta, '0);
        resetn = 1'b1;

        // Byte loads with sign/zero extension.
        do_req(3'd1, 2'd3, 32'h0);
        do_ok(32'h80FF_0000);
        chk("lb_data", out_data, 32'hFFFF_FF80);
        step();
        do_req(3'd2, 2'd3, 32'h0);
        do_ok(32'h80FF_0000);
        chk("lbu_data", out_data, 32'h0000_0080);
        step();

        // Fill, full, then drain in order.
        do_req(3'd0, 2'd0, 32'h0);
        do_req(3'd0, 2'd0, 32'h0);
        chk("full_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        step();
        do_ok(32'h11);
        do_ok(32'h22);
        step();
        chk("drained_ready", req_ready, 1'b1);

        // Backpressure holds the head.
        out_ready = 1'b0;
        do_req(3'd3, 2'd2, 32'h0);
        do_req(3'd4, 2'd0, 32'h0);
        do_ok(32'h8001_7FFE);
        do_ok(32'h1234_9ABC);
        repeat (3) begin
            step();
            chk("hold_data", out_data, 32'hFFFF_8001);
        end
        out_ready = 1'b1;
        step();
        step();
        step();

        // Flush with two waiting entries; their responses are swallowed.
        do_req(3'd0, 2'd0, 32'h0);
        do_req(3'd0, 2'd0, 32'h0);
        flush = 1'b1;
        step();
        chk("flush_pending", pending_cnt, 2);
        do_ok(32'hDEAD_0001);
        do_ok(32'hDEAD_0002);
        do_req(3'd0, 2'd0, 32'h0);
        do_ok(32'hABCD_1234);
        chk("post_flush_data", out_data, 32'hABCD_1234);
        step();

        // Flush together with a response.
        do_req(3'd0, 2'd0, 32'h0);
        do_req(3'd0, 2'd0, 32'h0);
        flush = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_0003;
        step();
        chk("flush_ok_pending", pending_cnt, 1);
        do_ok(32'hDEAD_0004);
        do_req(3'd1, 2'd1, 32'h0);
        do_ok(32'h0000_7F00);
        step();

        // Partial-word loads.
        do_req(3'd5, 2'd1, 32'h1122_3344);
        do_ok(32'hAABB_CCDD);
`ifdef MEM_LWLR_EN
        chk("lwl_data", out_data, 32'hCCDD_3344);
`else
        chk("lwl_data", out_data, 32'hAABB_CCDD);
`endif
        step();
        do_req(3'd6, 2'd2, 32'h1122_3344);
        do_ok(32'hAABB_CCDD);
`ifdef MEM_LWLR_EN
        chk("lwr_data", out_data, 32'h1122_AABB);
`else
        chk("lwr_data", out_data, 32'hAABB_CCDD);
`endif
        step();

        // Random mix of pushes, responses, pops and flushes.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b1;
                req_op    = 3'($urandom_range(0, 7));
                req_off   = 2'($urandom_range(0, 3));
                req_rt    = $urandom();
                req_meta  = META_W'({$urandom(), $urandom()});
            end
            if ($urandom_range(0, 1) == 1 && (req_q.size() > 0 || m_drop > 0)) begin
                data_ok = 1'b1;
                rdata   = $urandom();
            end
            if ($urandom_range(0, 19) == 0) flush = 1'b1;
            step();
        end

        // Reset in the middle of traffic clears everything.
        do_req(3'd0, 2'd0, 32'h0);
        resetn = 1'b0;
        req_q.delete(); exp_q.delete(); stage_q.delete(); m_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_pending", pending_cnt, 0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        resetn = 1'b1;
        out_ready = 1'b1;
        do_req(3'd4, 2'd2, 32'h0);
        do_ok(32'hF00D_0000);
        chk("after_rst_data", out_data, 32'h0000_F00D);
        step();
        step();
        chk("final_pending", pending_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
